// File: rtl/ex_mem_pkg.sv
// ----------------------------------------------------------------------------
// ex_mem_pkg
// Shared types for the EX/MEM pipeline register.
//   XLEN_P / RA_W_P    : data-path and register-address widths of the payload
//   ex_mem_payload_t   : packed EX->MEM payload (data + control bits)
//   skid_state_e       : occupancy state of the two-slot pipe buffer
//   sanitise_payload() : clears regwrite for writes aimed at x0
// ----------------------------------------------------------------------------
package ex_mem_pkg;

  localparam int unsigned XLEN_P = 32;
  localparam int unsigned RA_W_P = 5;

  typedef struct packed {
    logic [XLEN_P-1:0] alu_result;
    logic [XLEN_P-1:0] store_data;
    logic [RA_W_P-1:0] rd;
    logic              regwrite;
    logic              memread;
    logic              memwrite;
  } ex_mem_payload_t;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } skid_state_e;

  // A write to x0 has no architectural effect, so it is dropped at load time.
  function automatic ex_mem_payload_t sanitise_payload(input ex_mem_payload_t p);
    ex_mem_payload_t r;
    r          = p;
    r.regwrite = p.regwrite & (p.rd != {RA_W_P{1'b0}});
    return r;
  endfunction

endpackage

// File: rtl/ex_mem_stage_reg_pipe_skid_buffer.sv
// ----------------------------------------------------------------------------
// pipe_skid_buffer
// Generic valid/ready pipeline register with an optional second (skid) slot.
//   W          : payload width
//   SKID       : 1 = two slots, registered in_ready_o
//                0 = one slot, in_ready_o = !out_valid_o || out_ready_i
//   clk_i, reset_i (async, active-high), flush_i (sync kill of all entries)
//   in_valid_i / in_ready_o / in_data_i    : upstream handshake
//   out_valid_o / out_ready_i / out_data_o : downstream handshake
// The main slot always holds the oldest entry; it drives out_data_o directly,
// so there is no combinational path from in_data_i to out_data_o.
// ----------------------------------------------------------------------------
module pipe_skid_buffer
  import ex_mem_pkg::*;
#(
  parameter int unsigned W    = 8,
  parameter bit          SKID = 1'b1
) (
  input  logic         clk_i,
  input  logic         reset_i,
  input  logic         flush_i,
  input  logic         in_valid_i,
  output logic         in_ready_o,
  input  logic [W-1:0] in_data_i,
  output logic         out_valid_o,
  input  logic         out_ready_i,
  output logic [W-1:0] out_data_o
);

  skid_state_e  state_q;
  logic [W-1:0] main_q;
  logic [W-1:0] skid_q;
  logic         rdy_q;
  logic         accept_s;
  logic         pop_s;

  assign out_valid_o = (state_q != EMPTY);
  assign out_data_o  = main_q;
  // Skid mode uses a registered "not FULL" decode, independent of out_ready_i.
  assign in_ready_o  = SKID ? rdy_q : (!out_valid_o || out_ready_i);
  assign accept_s    = in_valid_i && in_ready_o;
  assign pop_s       = out_valid_o && out_ready_i;

  // Occupancy state machine and slot storage; flush overrides everything.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q <= EMPTY;
      main_q  <= {W{1'b0}};
      skid_q  <= {W{1'b0}};
      rdy_q   <= 1'b1;
    end else if (flush_i) begin
      // Slot data is kept so invalid outputs hold their last value.
      state_q <= EMPTY;
      rdy_q   <= 1'b1;
    end else begin
      case (state_q)
        EMPTY: begin
          if (accept_s) begin
            main_q  <= in_data_i;
            state_q <= ONE;
          end
          rdy_q <= 1'b1;
        end
        ONE: begin
          if (accept_s && pop_s) begin
            main_q <= in_data_i;
          end else if (accept_s && SKID) begin
            skid_q  <= in_data_i;
            state_q <= FULL;
            rdy_q   <= 1'b0;
          end else if (pop_s) begin
            state_q <= EMPTY;
          end
        end
        FULL: begin
          // No accept is possible here; a pop promotes the younger entry.
          if (pop_s) begin
            main_q  <= skid_q;
            state_q <= ONE;
            rdy_q   <= 1'b1;
          end
        end
        default: begin
          state_q <= EMPTY;
          rdy_q   <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: rtl/ex_mem_stage_reg.sv
// ----------------------------------------------------------------------------
// ex_mem_stage_reg
// Flow-controlled EX/MEM pipeline register of the RISC-V core.
//   XLEN, RA_W : payload widths (must match ex_mem_pkg::XLEN_P / RA_W_P)
//   SKID       : 1 = 2-entry skid buffer, 0 = single entry
//   CNT_W      : width of the saturating stall counter
//   clk, reset (async, active-high), flush (sync kill)
//   in_*  : EX-side payload and valid/ready handshake
//   out_* : MEM-side registered payload; control bits read 0 when invalid
//   stall_cnt : cycles with out_valid && !out_ready, saturating, reset-only
// ----------------------------------------------------------------------------
module ex_mem_stage_reg
  import ex_mem_pkg::*;
#(
  parameter int unsigned XLEN  = XLEN_P,
  parameter int unsigned RA_W  = RA_W_P,
  parameter int unsigned SKID  = 1,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [XLEN-1:0]  in_alu_result,
  input  logic [XLEN-1:0]  in_store_data,
  input  logic [RA_W-1:0]  in_rd,
  input  logic             in_regwrite,
  input  logic             in_memread,
  input  logic             in_memwrite,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_alu_result,
  output logic [XLEN-1:0]  out_store_data,
  output logic [RA_W-1:0]  out_rd,
  output logic             out_regwrite,
  output logic             out_memread,
  output logic             out_memwrite,
  output logic [CNT_W-1:0] stall_cnt
);

  localparam int unsigned PW = $bits(ex_mem_payload_t);

  ex_mem_payload_t  in_raw_s;
  ex_mem_payload_t  in_pl_s;
  ex_mem_payload_t  out_pl_s;
  logic [PW-1:0]    out_vec_s;
  logic [CNT_W-1:0] stall_q;
  logic [CNT_W-1:0] stall_d;

  assign in_raw_s.alu_result = in_alu_result;
  assign in_raw_s.store_data = in_store_data;
  assign in_raw_s.rd         = in_rd;
  assign in_raw_s.regwrite   = in_regwrite;
  assign in_raw_s.memread    = in_memread;
  assign in_raw_s.memwrite   = in_memwrite;
  assign in_pl_s             = sanitise_payload(in_raw_s);

  pipe_skid_buffer #(
    .W    (PW),
    .SKID (SKID != 0)
  ) u_buf (
    .clk_i       (clk),
    .reset_i     (reset),
    .flush_i     (flush),
    .in_valid_i  (in_valid),
    .in_ready_o  (in_ready),
    .in_data_i   (in_pl_s),
    .out_valid_o (out_valid),
    .out_ready_i (out_ready),
    .out_data_o  (out_vec_s)
  );

  assign out_pl_s       = ex_mem_payload_t'(out_vec_s);
  assign out_alu_result = out_pl_s.alu_result;
  assign out_store_data = out_pl_s.store_data;
  assign out_rd         = out_pl_s.rd;
  // Bubbles must never carry a side effect into MEM.
  assign out_regwrite   = out_valid & out_pl_s.regwrite;
  assign out_memread    = out_valid & out_pl_s.memread;
  assign out_memwrite   = out_valid & out_pl_s.memwrite;
  assign stall_cnt      = stall_q;

  // Next stall count: bump on a backpressured valid cycle unless saturated.
  always_comb begin
    stall_d = stall_q;
    if (out_valid && !out_ready && (stall_q != {CNT_W{1'b1}})) begin
      stall_d = stall_q + CNT_W'(1);
    end else begin
      stall_d = stall_q;
    end
  end

  // Stall counter register; flush deliberately does not clear it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_q <= {CNT_W{1'b0}};
    end else begin
      stall_q <= stall_d;
    end
  end

endmodule

// File: tb/tb_ex_mem_stage_reg.sv
module tb_ex_mem_stage_reg;

  typedef struct packed {
    logic [31:0] alu;
    logic [31:0] sd;
    logic [4:0]  rd;
    logic        rw;
    logic        mr;
    logic        mw;
  } pl_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, flush, in_valid, out_ready;
  logic [31:0] in_alu, in_sd;
  logic [4:0]  in_rd;
  logic        in_rw, in_mr, in_mw;

  logic        a_in_ready, a_out_valid, a_rw, a_mr, a_mw;
  logic [31:0] a_alu, a_sd;
  logic [4:0]  a_rd;
  logic [15:0] a_stall;
  logic        b_in_ready, b_out_valid, b_rw, b_mr, b_mw;
  logic [31:0] b_alu, b_sd;
  logic [4:0]  b_rd;
  logic [1:0]  b_stall;

  ex_mem_stage_reg #(.XLEN(32), .RA_W(5), .SKID(1), .CNT_W(16)) dut_a (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(a_in_ready),
    .in_alu_result(in_alu), .in_store_data(in_sd), .in_rd(in_rd), .in_regwrite(in_rw),
    .in_memread(in_mr), .in_memwrite(in_mw), .out_valid(a_out_valid), .out_ready(out_ready),
    .out_alu_result(a_alu), .out_store_data(a_sd), .out_rd(a_rd), .out_regwrite(a_rw),
    .out_memread(a_mr), .out_memwrite(a_mw), .stall_cnt(a_stall));

  ex_mem_stage_reg #(.XLEN(32), .RA_W(5), .SKID(0), .CNT_W(2)) dut_b (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(b_in_ready),
    .in_alu_result(in_alu), .in_store_data(in_sd), .in_rd(in_rd), .in_regwrite(in_rw),
    .in_memread(in_mr), .in_memwrite(in_mw), .out_valid(b_out_valid), .out_ready(out_ready),
    .out_alu_result(b_alu), .out_store_data(b_sd), .out_rd(b_rd), .out_regwrite(b_rw),
    .out_memread(b_mr), .out_memwrite(b_mw), .stall_cnt(b_stall));

  int  checks = 0;
  int  errors = 0;
  // Reference model: a FIFO per instance (capacity 2 / 1), the payload last
  // seen at the head (what the data outputs show), and the stall count.
  pl_t q1[$];
  pl_t q0[$];
  pl_t last1, last0;
  int  st1, st0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    q1.delete();
    q0.delete();
    last1 = '0;
    last0 = '0;
    st1   = 0;
    st0   = 0;
  endtask

  function automatic pl_t cur_in();
    pl_t p;
    p.alu = in_alu;
    p.sd  = in_sd;
    p.rd  = in_rd;
    p.rw  = in_rw && (in_rd != 5'd0);
    p.mr  = in_mr;
    p.mw  = in_mw;
    return p;
  endfunction

  task automatic check_all();
    pl_t h1, h0;
    h1 = (q1.size() > 0) ? q1[0] : '0;
    h0 = (q0.size() > 0) ? q0[0] : '0;
    chk("a_out_valid", 64'(a_out_valid), 64'(q1.size() > 0));
    chk("a_in_ready",  64'(a_in_ready),  64'(q1.size() < 2));
    chk("a_alu",       64'(a_alu),       64'(last1.alu));
    chk("a_store",     64'(a_sd),        64'(last1.sd));
    chk("a_rd",        64'(a_rd),        64'(last1.rd));
    chk("a_ctrl",      64'({a_rw, a_mr, a_mw}), 64'({h1.rw, h1.mr, h1.mw}));
    chk("a_stall",     64'(a_stall),     64'(st1));
    chk("b_out_valid", 64'(b_out_valid), 64'(q0.size() > 0));
    chk("b_in_ready",  64'(b_in_ready),  64'((q0.size() == 0) || out_ready));
    chk("b_alu",       64'(b_alu),       64'(last0.alu));
    chk("b_store",     64'(b_sd),        64'(last0.sd));
    chk("b_rd",        64'(b_rd),        64'(last0.rd));
    chk("b_ctrl",      64'({b_rw, b_mr, b_mw}), 64'({h0.rw, h0.mr, h0.mw}));
    chk("b_stall",     64'(b_stall),     64'(st0));
  endtask

  task automatic set_in(input logic v, input logic rdy, input logic fl, input logic [31:0] alu,
                        input logic [31:0] sd, input logic [4:0] rd, input logic rw,
                        input logic mr, input logic mw);
    in_valid  = v;
    out_ready = rdy;
    flush     = fl;
    in_alu    = alu;
    in_sd     = sd;
    in_rd     = rd;
    in_rw     = rw;
    in_mr     = mr;
    in_mw     = mw;
  endtask

  task automatic set_rand(input logic v, input logic rdy, input logic fl);
    set_in(v, rdy, fl, $urandom, $urandom, 5'($urandom_range(0, 31)),
           1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
  endtask

  // One clock cycle: called at a negedge with inputs applied; checks, then
  // advances the model by the handshake rules across the rising edge.
  task automatic step(output bit acc0_o);
    bit  acc1, pop1, acc0, pop0;
    pl_t p;
    #1;
    check_all();
    acc1 = in_valid && (q1.size() < 2);
    pop1 = (q1.size() > 0) && out_ready;
    acc0 = in_valid && ((q0.size() == 0) || out_ready);
    pop0 = (q0.size() > 0) && out_ready;
    if ((q1.size() > 0) && !out_ready && (st1 < 65535)) st1++;
    if ((q0.size() > 0) && !out_ready && (st0 < 3)) st0++;
    p = cur_in();
    @(posedge clk);
    if (flush) begin
      q1.delete();
      q0.delete();
      acc0 = 1'b0;
    end else begin
      if (pop1) void'(q1.pop_front());
      if (acc1) q1.push_back(p);
      if (pop0) void'(q0.pop_front());
      if (acc0) q0.push_back(p);
    end
    if (q1.size() > 0) last1 = q1[0];
    if (q0.size() > 0) last0 = q0[0];
    acc0_o = acc0;
    @(negedge clk);
  endtask

  initial begin
    bit acc;
    int n;
    logic r;

    reset = 1'b1;
    set_in(1'b0, 1'b1, 1'b0, 32'd0, 32'd0, 5'd0, 1'b0, 1'b0, 1'b0);
    model_reset();
    #1;
    check_all();
    @(negedge clk);
    reset = 1'b0;

    // Single transfer, released from reset with in_valid high.
    set_in(1'b1, 1'b1, 1'b0, 32'h0000_1234, 32'hCAFE_0001, 5'd5, 1'b1, 1'b0, 1'b0);
    step(acc);
    set_in(1'b0, 1'b1, 1'b0, 32'd0, 32'd0, 5'd0, 1'b0, 1'b0, 1'b0);
    #1;
    chk("t1_valid",    64'(a_out_valid), 64'd1);
    chk("t1_alu",      64'(a_alu),       64'h1234);
    chk("t1_regwrite", 64'(a_rw),        64'd1);
    chk("t1_in_ready", 64'(a_in_ready),  64'd1);
    step(acc);

    // Backpressure: A, B accepted, C held until out_ready returns.
    set_in(1'b1, 1'b0, 1'b0, 32'hA, 32'h1A, 5'd1, 1'b1, 1'b0, 1'b0); step(acc);
    set_in(1'b1, 1'b0, 1'b0, 32'hB, 32'h1B, 5'd2, 1'b0, 1'b1, 1'b0); step(acc);
    set_in(1'b1, 1'b0, 1'b0, 32'hC, 32'h1C, 5'd3, 1'b0, 1'b0, 1'b1);
    #1;
    chk("bp_in_ready_low", 64'(a_in_ready), 64'd0);
    step(acc);
    step(acc);
    out_ready = 1'b1;
    #1;
    chk("bp_stall_cnt", 64'(a_stall), 64'd3);
    chk("bp_head_A",    64'(a_alu),   64'hA);
    step(acc);
    step(acc);
    set_in(1'b0, 1'b1, 1'b0, 32'd0, 32'd0, 5'd0, 1'b0, 1'b0, 1'b0);
    step(acc);
    step(acc);

    // x0 destination: regwrite is dropped.
    set_in(1'b1, 1'b1, 1'b0, 32'h5555_AAAA, 32'h0, 5'd0, 1'b1, 1'b0, 1'b0);
    step(acc);
    set_in(1'b0, 1'b1, 1'b0, 32'd0, 32'd0, 5'd0, 1'b0, 1'b0, 1'b0);
    #1;
    chk("x0_valid",    64'(a_out_valid), 64'd1);
    chk("x0_regwrite", 64'(a_rw),        64'd0);
    step(acc);

    // Flush while FULL with a simultaneous input.
    set_rand(1'b1, 1'b0, 1'b0); step(acc);
    set_rand(1'b1, 1'b0, 1'b0); step(acc);
    set_in(1'b1, 1'b0, 1'b1, 32'hDEAD_BEEF, 32'h0, 5'd7, 1'b1, 1'b1, 1'b1);
    step(acc);
    set_in(1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 5'd0, 1'b0, 1'b0, 1'b0);
    #1;
    chk("fl_valid",    64'(a_out_valid), 64'd0);
    chk("fl_ctrl",     64'({a_rw, a_mr, a_mw}), 64'd0);
    chk("fl_in_ready", 64'(a_in_ready),  64'd1);
    step(acc);
    out_ready = 1'b1;
    step(acc);

    // Asynchronous reset between edges while FULL.
    set_rand(1'b1, 1'b0, 1'b0); step(acc);
    set_rand(1'b1, 1'b0, 1'b0); step(acc);
    set_in(1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 5'd0, 1'b0, 1'b0, 1'b0);
    #2;
    reset = 1'b1;
    model_reset();
    #1;
    chk("rst_valid", 64'(a_out_valid), 64'd0);
    chk("rst_alu",   64'(a_alu),       64'd0);
    chk("rst_stall", 64'(a_stall),     64'd0);
    check_all();
    @(negedge clk);
    reset = 1'b0;
    set_in(1'b1, 1'b1, 1'b0, 32'h0BAD_F00D, 32'h77, 5'd9, 1'b1, 1'b1, 1'b0);
    step(acc);
    set_in(1'b0, 1'b1, 1'b0, 32'd0, 32'd0, 5'd0, 1'b0, 1'b0, 1'b0);
    #1;
    chk("rst_push_valid", 64'(a_out_valid), 64'd1);
    chk("rst_push_alu",   64'(a_alu),       64'h0BAD_F00D);
    step(acc);

    // Stream 8 payloads with out_ready toggling; held until SKID=0 accepts.
    n = 0;
    r = 1'b1;
    set_rand(1'b1, r, 1'b0);
    for (int k = 0; k < 40 && n < 8; k++) begin
      out_ready = r;
      step(acc);
      if (acc) begin
        n++;
        set_rand(1'b1, 1'b1, 1'b0);
      end
      r = ~r;
    end
    chk("stream_count", 64'(n), 64'd8);
    set_in(1'b0, 1'b1, 1'b0, 32'd0, 32'd0, 5'd0, 1'b0, 1'b0, 1'b0);
    step(acc);
    step(acc);
    #1;
    chk("b_stall_sat", 64'(b_stall), 64'd3);

    // Random traffic with occasional flushes.
    for (int k = 0; k < 400; k++) begin
      set_rand(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 2) != 0),
               1'($urandom_range(0, 15) == 0));
      step(acc);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
